// File: rtl/ci_issue_ctrl.sv
// Issues buffered operands to a multi-cycle custom-instruction slave one at a time,
// returns the result (or a timeout marker) downstream with its measured latency.
module ci_issue_ctrl #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clock,
  input  logic              aclr_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              ci_clk_en,
  output logic              ci_aclr,
  output logic              ci_start,
  output logic [DATA_W-1:0] ci_dataa,
  input  logic [DATA_W-1:0] ci_result,
  input  logic              ci_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_timeout,
  output logic [15:0]       out_latency,
  output logic              busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  state_t state, state_nxt;

  logic [FIFO_DEPTH-1:0][DATA_W-1:0] mem;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop, fifo_ne;
  logic [15:0]   cnt, cnt_inc;
  logic          hit_to;

  // ---------------- operand FIFO ----------------
  assign fifo_ne  = (count != '0);
  assign in_ready = (count != CW'(FIFO_DEPTH));
  assign push     = in_valid & in_ready;
  assign pop      = (state == S_IDLE) & fifo_ne;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------- FSM ----------------
  // cnt_inc is the WAIT-cycle count including the current cycle
  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  assign hit_to  = (cnt_inc == 16'(TIMEOUT));

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (fifo_ne) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (ci_done || hit_to) state_nxt = S_HOLD;
      S_HOLD:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ci_start  = (state == S_ISSUE);
    ci_clk_en = (state == S_ISSUE) || (state == S_WAIT);
    busy      = fifo_ne || (state != S_IDLE);
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      ci_dataa    <= '0;
      cnt         <= '0;
      ci_aclr     <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_timeout <= 1'b0;
      out_latency <= '0;
    end else begin
      ci_aclr <= 1'b0;
      if (pop) ci_dataa <= mem[rd_ptr];
      case (state)
        S_ISSUE: cnt <= '0;
        S_WAIT: begin
          cnt <= cnt_inc;
          // done takes priority over a timeout landing on the same cycle
          if (ci_done) begin
            out_data    <= ci_result;
            out_timeout <= 1'b0;
            out_latency <= cnt_inc;
            out_valid   <= 1'b1;
          end else if (hit_to) begin
            out_data    <= '0;
            out_timeout <= 1'b1;
            out_latency <= 16'(TIMEOUT);
            out_valid   <= 1'b1;
            ci_aclr     <= 1'b1;
          end
        end
        S_HOLD:  if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ci_issue_ctrl.sv
// Scoreboard bench: pushes record expected results; a negedge monitor models the
// slave and checks every presented result, handshake and hold behaviour.
module tb_ci_issue_ctrl;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int TO = 8;

  logic          clock = 1'b0;
  logic          aclr_n;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          ci_clk_en, ci_aclr, ci_start;
  logic [DW-1:0] ci_dataa, ci_result;
  logic          ci_done;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic          out_timeout;
  logic [15:0]   out_latency;
  logic          busy;

  always #5 clock = ~clock;

  ci_issue_ctrl #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clock(clock), .aclr_n(aclr_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ci_clk_en(ci_clk_en), .ci_aclr(ci_aclr), .ci_start(ci_start),
    .ci_dataa(ci_dataa), .ci_result(ci_result), .ci_done(ci_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_timeout(out_timeout), .out_latency(out_latency), .busy(busy)
  );

  typedef struct {
    logic [31:0] data;
    logic [15:0] lat;
    logic        to;
  } exp_t;

  int          n_chk = 0;
  int          n_fail = 0;
  int          ready_mode = 1;  // 0: hold low, 1: hold high, 2: random
  exp_t        res_q[$];
  logic [31:0] op_q[$];

  // Slave behaviour: latency and result are plain functions of the operand.
  function automatic int lat_of(input logic [31:0] op);
    return (op == 32'h41c80000) ? 5 : int'(op[3:0]) + 1;
  endfunction

  function automatic logic [31:0] res_of(input logic [31:0] op);
    return (op == 32'h41c80000) ? 32'h43deea9d : ({op[15:0], op[31:16]} ^ 32'h5a5aa5a5);
  endfunction

  function automatic exp_t expect_of(input logic [31:0] op);
    exp_t e;
    if (lat_of(op) > TO) begin
      e.data = 32'h0; e.lat = 16'(TO); e.to = 1'b1;
    end else begin
      e.data = res_of(op); e.lat = 16'(lat_of(op)); e.to = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // out_ready driver: changes only just after a rising edge
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clock); #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Slave model + scoreboard monitor, sampled on the falling edge
  initial begin
    logic [31:0] sl_op;
    logic        sl_act, prev_valid, prev_ready, prev_start, aclr_exp;
    int          sl_wcnt;
    exp_t        held, e;
    sl_act = 0; prev_valid = 0; prev_ready = 0; prev_start = 0; sl_wcnt = 0; sl_op = 0;
    held = '{32'h0, 16'h0, 1'b0};
    ci_done = 1'b0; ci_result = '0;
    forever begin
      @(negedge clock);
      if (!aclr_n) begin
        op_q.delete(); res_q.delete();
        sl_act = 0; prev_valid = 0; prev_ready = 0; prev_start = 0;
        ci_done = 1'b0;
        continue;
      end
      if (in_valid && in_ready) begin
        op_q.push_back(in_data);
        res_q.push_back(expect_of(in_data));
      end
      // slave: done noise is allowed during ISSUE and outside an operation
      if (ci_start) begin
        chk("start_one_cycle", 32'(prev_start), 0);
        if (op_q.size() == 0) chk("issue_without_operand", 1, 0);
        else begin
          sl_op = op_q.pop_front();
          chk("ci_dataa_issue", ci_dataa, sl_op);
        end
        chk("ci_clk_en_issue", 32'(ci_clk_en), 1);
        sl_act = 1; sl_wcnt = 0;
        ci_done = 1'($urandom_range(0, 1)); ci_result = $urandom;
      end else if (sl_act) begin
        chk("ci_clk_en_wait", 32'(ci_clk_en), 1);
        chk("ci_dataa_stable", ci_dataa, sl_op);
        sl_wcnt++;
        ci_done = 1'b0; ci_result = $urandom;
        if (sl_wcnt == lat_of(sl_op)) begin
          ci_done = 1'b1; ci_result = res_of(sl_op); sl_act = 0;
        end else if (sl_wcnt >= TO) sl_act = 0;
      end else begin
        ci_done = ($urandom_range(0, 3) == 0); ci_result = $urandom;
      end
      // result side
      aclr_exp = 1'b0;
      if (out_valid) begin
        chk("hold_clk_en", 32'(ci_clk_en), 0);
        chk("hold_no_start", 32'(ci_start), 0);
      end
      if (prev_valid && prev_ready) begin
        chk("valid_drop", 32'(out_valid), 0);
      end else if (out_valid && !prev_valid) begin
        if (res_q.size() == 0) chk("unexpected_output", 1, 0);
        else begin
          e = res_q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_latency", 32'(out_latency), 32'(e.lat));
          chk("out_timeout", 32'(out_timeout), 32'(e.to));
          aclr_exp = e.to;
          held = e;
        end
      end else if (out_valid) begin
        chk("hold_data", out_data, held.data);
        chk("hold_latency", 32'(out_latency), 32'(held.lat));
      end
      chk("ci_aclr", 32'(ci_aclr), 32'(aclr_exp));
      prev_valid = out_valid; prev_ready = out_ready; prev_start = ci_start;
    end
  end

  // Call just after a rising edge; returns just after the accepting edge.
  task automatic push(input logic [31:0] op);
    in_valid = 1'b1; in_data = op;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (in_ready) begin
        @(posedge clock); #1;
        in_valid = 1'b0;
        return;
      end
    end
    chk("push_accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (res_q.size() == 0 && !busy && !out_valid) begin
        @(posedge clock); #1;
        return;
      end
    end
    chk({name, "_drain_timeout"}, 0, 1);
    @(posedge clock); #1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_ci_start"}, 32'(ci_start), 0);
    chk({tag, "_ci_clk_en"}, 32'(ci_clk_en), 0);
    chk({tag, "_ci_aclr"}, 32'(ci_aclr), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_timeout"}, 32'(out_timeout), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_ci_dataa"}, ci_dataa, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_latency"}, 32'(out_latency), 0);
    chk({tag, "_in_ready"}, 32'(in_ready), 1);
  endtask

  initial begin
    aclr_n = 1'b1; in_valid = 1'b0; in_data = '0;
    #1 aclr_n = 1'b0;
    #1 reset_checks("reset");
    repeat (3) @(posedge clock);
    #1 aclr_n = 1'b1;
    @(posedge clock); #1;

    // single operation
    ready_mode = 1;
    push(32'h41c80000);
    wait_drain("single", 100);

    // FIFO fill under backpressure, then ordered release
    ready_mode = 0;
    push(32'h00000000);
    push(32'h41c80000);
    push(32'h42480000);
    push(32'h42960000);
    push(32'h42c80000);
    in_valid = 1'b1; in_data = 32'h42f00000;
    repeat (20) begin
      @(negedge clock);
      chk("in_ready_full", 32'(in_ready), 0);
    end
    ready_mode = 1;
    push(32'h42f00000);
    wait_drain("fifo_order", 300);

    // timeout followed by a normal op, then done/timeout tie and first-cycle done
    push(32'h0000000f);
    push(32'h00000123);
    push(32'h00000007);
    push(32'h00000010);
    wait_drain("timeout_tie", 300);

    // reset while an operation is in WAIT with 3 operands queued
    push(32'h0000001f);
    push(32'h0000002f);
    push(32'h0000003f);
    push(32'h0000004f);
    @(posedge clock); #3;
    aclr_n = 1'b0;
    #1 reset_checks("midreset");
    repeat (2) @(posedge clock);
    #1 aclr_n = 1'b1;
    repeat (20) @(posedge clock);
    #1 chk("post_reset_busy", 32'(busy), 0);
    chk("post_reset_out_valid", 32'(out_valid), 0);
    push(32'h41c80000);
    wait_drain("post_reset", 100);

    // randomized traffic with random downstream backpressure
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      push($urandom);
      repeat ($urandom_range(0, 2)) @(posedge clock);
      #1;
    end
    wait_drain("random", 3000);

    chk("scoreboard_empty", 32'(res_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1, "time limit");
  end

endmodule
